alu_arbiter: RTL and testbench

- Shares one combinational ALU instance among Requesters independent clients, e.g. the execute stage, the address-generation path and the debug unit.
- Round-robin arbitration with a valid/ready handshake on each request port and on the single response port.
- Drives the ALU operand and control inputs from registered state, captures the ALU result and flags into a response register, and masks flags that are not meaningful for the issued operation.

---
 rtl/alu_arbiter.sv | 271 +++++++++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter_pkg: operation codes shared by the arbiter, its clients and the ALU.
//
// alu_arbiter: shares one combinational ALU among Requesters clients.
//   - Round-robin grant with a valid/ready handshake per request port.
//   - Single response port with a valid/ready handshake.
//   - ALU inputs come from registered operands; result and flags are captured into
//     a response register, and flags that mean nothing for the issued op are masked.
//
// Ports:
//   clk, rst_n     rising-edge clock, synchronous active-low reset
//   req_valid      per-client request valid
//   req_ready      per-client accept (combinational, at most one bit high)
//   req_a, req_b   packed operands, client i at [i*BitWidth +: BitWidth]
//   req_control    packed operation codes, client i at [i*AluCodeWidth +: AluCodeWidth]
//   alu_a, alu_b   operands to the shared ALU
//   alu_control    operation to the shared ALU (NONE outside EXEC)
//   alu_c          result from the shared ALU
//   alu_flags      {zero, carry, negative, overflow} from the shared ALU
//   resp_valid     response valid
//   resp_ready     response accept
//   resp_id        index of the client owning the response
//   resp_c         captured result
//   resp_flags     captured, masked {zero, carry, negative, overflow}

package alu_arbiter_pkg;

   parameter int unsigned AluCodeWidth = 4;

   typedef enum logic [AluCodeWidth-1:0] {
      AluNone = 4'd0,
      AluAdd  = 4'd1,
      AluAddu = 4'd2,
      AluSub  = 4'd3,
      AluSubu = 4'd4,
      AluSlt  = 4'd5,
      AluSltu = 4'd6,
      AluAnd  = 4'd7,
      AluOr   = 4'd8,
      AluXor  = 4'd9,
      AluNor  = 4'd10,
      AluSll  = 4'd11,
      AluSrl  = 4'd12,
      AluSra  = 4'd13,
      AluLui  = 4'd14
   } alu_code_e;

endpackage

module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int unsigned BitWidth   = 32,
   parameter int unsigned Requesters = 2,
   parameter int unsigned IdWidth    = (Requesters > 1) ? $clog2(Requesters) : 1
) (
   input  logic                               clk,
   input  logic                               rst_n,

   input  logic [Requesters-1:0]              req_valid,
   output logic [Requesters-1:0]              req_ready,
   input  logic [Requesters*BitWidth-1:0]     req_a,
   input  logic [Requesters*BitWidth-1:0]     req_b,
   input  logic [Requesters*AluCodeWidth-1:0] req_control,

   output logic [BitWidth-1:0]                alu_a,
   output logic [BitWidth-1:0]                alu_b,
   output alu_code_e                          alu_control,
   input  logic [BitWidth-1:0]                alu_c,
   input  logic [3:0]                         alu_flags,

   output logic                               resp_valid,
   input  logic                               resp_ready,
   output logic [IdWidth-1:0]                 resp_id,
   output logic [BitWidth-1:0]                resp_c,
   output logic [3:0]                         resp_flags
);

   typedef enum logic [1:0] {
      StIdle,
      StExec,
      StResp
   } state_e;

   state_e               state_q, state_d;
   logic [IdWidth-1:0]   last_q, last_d;
   logic [IdWidth-1:0]   id_q, id_d;
   logic [BitWidth-1:0]  a_q, a_d;
   logic [BitWidth-1:0]  b_q, b_d;
   alu_code_e            op_q, op_d;
   logic                 resp_valid_q, resp_valid_d;
   logic [IdWidth-1:0]   resp_id_q, resp_id_d;
   logic [BitWidth-1:0]  resp_c_q, resp_c_d;
   logic [3:0]           resp_flags_q, resp_flags_d;

   // ------------------------------------------------------------------
   // Arbitration
   // ------------------------------------------------------------------
   logic               accept;
   logic               grant_valid;
   logic [IdWidth-1:0] grant_id;
   logic [31:0]        scan_idx;
   logic [IdWidth-1:0] scan_cand;
   logic               load;

   // A new request may enter when nothing is in flight, or when the held
   // response leaves in this very cycle.
   always_comb begin
      accept = rst_n && ((state_q == StIdle) || ((state_q == StResp) && resp_ready));
   end

   // Scan last+1, last+2, ... so the most recent winner has lowest priority.
   always_comb begin
      grant_valid = 1'b0;
      grant_id    = '0;
      scan_idx    = '0;
      scan_cand   = '0;
      for (int unsigned k = 1; k <= Requesters; k++) begin
         scan_idx  = (32'(last_q) + k) % Requesters;
         scan_cand = IdWidth'(scan_idx);
         if (!grant_valid && req_valid[scan_cand]) begin
            grant_valid = 1'b1;
            grant_id    = scan_cand;
         end
      end
   end

   always_comb begin
      load = accept && grant_valid;
   end

   always_comb begin
      req_ready = '0;
      if (load) begin
         req_ready[grant_id] = 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Flag masking
   // ------------------------------------------------------------------
   logic       carry_ok;
   logic       ovf_ok;
   logic [3:0] flags_masked;

   always_comb begin
      carry_ok = 1'b0;
      ovf_ok   = 1'b0;
      case (op_q)
         AluAdd, AluSub: begin
            carry_ok = 1'b1;
            ovf_ok   = 1'b1;
         end
         AluAddu, AluSubu, AluSltu, AluSra, AluSrl, AluSll: begin
            carry_ok = 1'b1;
         end
         default: begin
            carry_ok = 1'b0;
            ovf_ok   = 1'b0;
         end
      endcase
      // Bit order {zero, carry, negative, overflow}.
      flags_masked = {alu_flags[3], alu_flags[2] & carry_ok, alu_flags[1], alu_flags[0] & ovf_ok};
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      last_d       = last_q;
      id_d         = id_q;
      a_d          = a_q;
      b_d          = b_q;
      op_d         = op_q;
      resp_valid_d = resp_valid_q;
      resp_id_d    = resp_id_q;
      resp_c_d     = resp_c_q;
      resp_flags_d = resp_flags_q;

      case (state_q)
         StIdle: begin
            if (load) begin
               state_d = StExec;
            end
         end

         StExec: begin
            resp_valid_d = 1'b1;
            resp_id_d    = id_q;
            // A NONE op never drove the ALU, so whatever it shows is not ours.
            if (op_q == AluNone) begin
               resp_c_d     = '0;
               resp_flags_d = '0;
            end else begin
               resp_c_d     = alu_c;
               resp_flags_d = flags_masked;
            end
            state_d = StResp;
         end

         StResp: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               state_d      = load ? StExec : StIdle;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase

      if (load) begin
         a_d    = req_a[32'(grant_id) * BitWidth +: BitWidth];
         b_d    = req_b[32'(grant_id) * BitWidth +: BitWidth];
         op_d   = alu_code_e'(req_control[32'(grant_id) * AluCodeWidth +: AluCodeWidth]);
         id_d   = grant_id;
         last_d = grant_id;
      end
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         last_q       <= IdWidth'(Requesters - 1);
         id_q         <= '0;
         a_q          <= '0;
         b_q          <= '0;
         op_q         <= AluNone;
         resp_valid_q <= 1'b0;
         resp_id_q    <= '0;
         resp_c_q     <= '0;
         resp_flags_q <= '0;
      end else begin
         state_q      <= state_d;
         last_q       <= last_d;
         id_q         <= id_d;
         a_q          <= a_d;
         b_q          <= b_d;
         op_q         <= op_d;
         resp_valid_q <= resp_valid_d;
         resp_id_q    <= resp_id_d;
         resp_c_q     <= resp_c_d;
         resp_flags_q <= resp_flags_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   always_comb begin
      if (state_q == StExec) begin
         alu_a       = a_q;
         alu_b       = b_q;
         alu_control = op_q;
      end else begin
         alu_a       = '0;
         alu_b       = '0;
         alu_control = AluNone;
      end
   end

   assign resp_valid = resp_valid_q;
   assign resp_id    = resp_id_q;
   assign resp_c     = resp_c_q;
   assign resp_flags = resp_flags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: models the shared ALU, keeps a scoreboard of
// expected responses filled at request handshakes and drained at response
// handshakes, and runs one task per scenario.

module tb_alu_arbiter;
   import alu_arbiter_pkg::*;

   localparam int unsigned W  = 32;
   localparam int unsigned N  = 2;
   localparam int unsigned IW = 1;

   logic                 clk;
   logic                 rst_n;
   logic [N-1:0]         req_valid;
   logic [N-1:0]         req_ready;
   logic [N*W-1:0]       req_a;
   logic [N*W-1:0]       req_b;
   logic [N*4-1:0]       req_control;
   logic [W-1:0]         alu_a;
   logic [W-1:0]         alu_b;
   alu_code_e            alu_control;
   logic [W-1:0]         alu_c;
   logic [3:0]           alu_flags;
   logic                 resp_valid;
   logic                 resp_ready;
   logic [IW-1:0]        resp_id;
   logic [W-1:0]         resp_c;
   logic [3:0]           resp_flags;

   logic stale_en;
   int   checks;
   int   failures;

   typedef struct packed {
      logic [IW-1:0] id;
      logic [W-1:0]  c;
      logic [3:0]    f;
   } exp_t;

   exp_t exp_q[$];

   alu_arbiter #(
      .BitWidth  (W),
      .Requesters(N)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_control(req_control),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_control(alu_control),
      .alu_c      (alu_c),
      .alu_flags  (alu_flags),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_id    (resp_id),
      .resp_c     (resp_c),
      .resp_flags (resp_flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference ALU: returns {c, zero, carry, negative, overflow}.
   // NONE yields junk so a response that used it stands out.
   function automatic logic [35:0] alu_model(alu_code_e op, logic [31:0] a, logic [31:0] b);
      logic [32:0] s;
      logic [31:0] c;
      logic        cy;
      logic        ov;
      s  = '0;
      c  = '0;
      cy = 1'b0;
      ov = 1'b0;
      case (op)
         AluAdd, AluAddu: begin
            s  = {1'b0, a} + {1'b0, b};
            c  = s[31:0];
            cy = s[32];
            ov = (a[31] == b[31]) && (c[31] != a[31]);
         end
         AluSub, AluSubu, AluSlt, AluSltu: begin
            s  = {1'b0, a} + {1'b0, ~b} + 33'd1;
            c  = s[31:0];
            cy = s[32];
            ov = (a[31] != b[31]) && (s[31] != a[31]);
            if (op == AluSlt) c = {31'b0, $signed(a) < $signed(b)};
            if (op == AluSltu) c = {31'b0, a < b};
         end
         AluAnd: c = a & b;
         AluOr:  c = a | b;
         AluXor: c = a ^ b;
         AluNor: c = ~(a | b);
         AluSll: c = a << b[4:0];
         AluSrl: c = a >> b[4:0];
         AluSra: c = $signed(a) >>> b[4:0];
         AluLui: c = {b[15:0], 16'h0};
         default: return {32'hDEADBEEF, 4'hF};
      endcase
      return {c, c == 32'd0, cy, c[31], ov};
   endfunction

   function automatic logic [3:0] mask_flags(alu_code_e op, logic [3:0] f);
      logic cy_ok;
      logic ov_ok;
      ov_ok = op inside {AluAdd, AluSub};
      cy_ok = op inside {AluAddu, AluAdd, AluSubu, AluSub, AluSltu, AluSra, AluSrl, AluSll};
      return {f[3], f[2] & cy_ok, f[1], f[0] & ov_ok};
   endfunction

   always_comb begin
      {alu_c, alu_flags} = alu_model(alu_control, alu_a, alu_b);
      if (stale_en) alu_flags = alu_flags | 4'b0101;
   end

   // Scoreboard monitor, sampled on the falling edge so values match the next rising edge.
   always @(negedge clk) begin
      if (rst_n) begin
         checks++;
         if ($countones(req_ready) > 1) begin
            failures++;
            $display("FAIL ready_onehot: req_ready=%b, required at most one bit", req_ready);
         end
         for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               exp_t       e;
               alu_code_e  op;
               logic [35:0] r;
               op = alu_code_e'(req_control[i*4 +: 4]);
               r  = alu_model(op, req_a[i*W +: W], req_b[i*W +: W]);
               if (stale_en) r[3:0] = r[3:0] | 4'b0101;
               e.id = IW'(i);
               if (op == AluNone) begin
                  e.c = '0;
                  e.f = '0;
               end else begin
                  e.c = r[35:4];
                  e.f = mask_flags(op, r[3:0]);
               end
               exp_q.push_back(e);
            end
         end
         if (resp_valid && resp_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL sb_unexpected: response id=%0d c=%h flags=%b, required none",
                        resp_id, resp_c, resp_flags);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if (resp_id !== e.id || resp_c !== e.c || resp_flags !== e.f) begin
                  failures++;
                  $display("FAIL sb_resp: got id=%0d c=%h flags=%b, required id=%0d c=%h flags=%b",
                           resp_id, resp_c, resp_flags, e.id, e.c, e.f);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(int i, alu_code_e op, logic [31:0] a, logic [31:0] b);
      req_valid[i]        = 1'b1;
      req_a[i*W +: W]     = a;
      req_b[i*W +: W]     = b;
      req_control[i*4 +: 4] = op;
   endtask

   task automatic apply_reset();
      rst_n      = 1'b0;
      req_valid  = '0;
      resp_ready = 1'b0;
      tick();
      tick();
      exp_q.delete();
      rst_n = 1'b1;
   endtask

   task automatic drain();
      for (int k = 0; k < 20; k++) begin
         if (exp_q.size() == 0) break;
         tick();
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      set_req(0, AluAdd, 32'd1, 32'd2);
      set_req(1, AluSub, 32'd3, 32'd4);
      resp_ready = 1'b1;
      tick();
      @(negedge clk);
      checks += 6;
      if (req_ready !== 2'b00) begin
         failures++; $display("FAIL rst_ready: got %b required 00", req_ready);
      end
      if (resp_valid !== 1'b0) begin
         failures++; $display("FAIL rst_valid: got %b required 0", resp_valid);
      end
      if (resp_id !== 1'b0) begin
         failures++; $display("FAIL rst_id: got %0d required 0", resp_id);
      end
      if (resp_c !== 32'd0) begin
         failures++; $display("FAIL rst_c: got %h required 0", resp_c);
      end
      if (resp_flags !== 4'd0) begin
         failures++; $display("FAIL rst_flags: got %b required 0000", resp_flags);
      end
      if (alu_control !== AluNone || alu_a !== 32'd0) begin
         failures++; $display("FAIL rst_alu: got ctl=%0d a=%h required NONE/0", alu_control, alu_a);
      end
      tick();
      req_valid = '0;
      exp_q.delete();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single_add();
      resp_ready = 1'b1;
      set_req(0, AluAdd, 32'h7FFF_FFFF, 32'h0000_0001);
      @(negedge clk);
      checks++;
      if (req_ready !== 2'b01) begin
         failures++; $display("FAIL add_ready: got %b required 01", req_ready);
      end
      tick();
      req_valid[0] = 1'b0;
      @(negedge clk);
      checks += 2;
      if (alu_control !== AluAdd || alu_a !== 32'h7FFF_FFFF || alu_b !== 32'd1) begin
         failures++;
         $display("FAIL add_alu: got ctl=%0d a=%h b=%h required ADD/7fffffff/1",
                  alu_control, alu_a, alu_b);
      end
      if (resp_valid !== 1'b0) begin
         failures++; $display("FAIL add_exec_valid: got %b required 0", resp_valid);
      end
      tick();
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1 || resp_id !== 1'b0 || resp_c !== 32'h8000_0000 ||
          resp_flags !== 4'b0011) begin
         failures++;
         $display("FAIL add_resp: got v=%b id=%0d c=%h f=%b required 1/0/80000000/0011",
                  resp_valid, resp_id, resp_c, resp_flags);
      end
      tick();
      drain();
   endtask

   task automatic test_fairness();
      int grants[$];
      int cycles[$];
      apply_reset();
      resp_ready = 1'b1;
      set_req(0, AluAddu, 32'd1, 32'd1);
      set_req(1, AluAddu, 32'd1, 32'd1);
      for (int cyc = 0; cyc < 8; cyc++) begin
         @(negedge clk);
         if (req_ready != 2'b00) begin
            grants.push_back(req_ready[1] ? 1 : 0);
            cycles.push_back(cyc);
         end
         tick();
         if (grants.size() == 4) req_valid = '0;
      end
      checks++;
      if (grants.size() != 4) begin
         failures++; $display("FAIL rr_count: got %0d grants required 4", grants.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (grants[k] != k % 2) begin
               failures++; $display("FAIL rr_order%0d: got client %0d required %0d", k, grants[k], k % 2);
            end
         end
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (cycles[k+1] - cycles[k] != 2) begin
               failures++;
               $display("FAIL rr_spacing%0d: got %0d cycles required 2", k, cycles[k+1] - cycles[k]);
            end
         end
      end
      drain();
   endtask

   task automatic test_backpressure();
      resp_ready = 1'b0;
      set_req(0, AluSubu, 32'd3, 32'd3);
      @(negedge clk);
      tick();
      req_valid[0] = 1'b0;
      set_req(1, AluAdd, 32'd5, 32'd6);
      @(negedge clk);
      tick();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checks += 2;
         if (resp_valid !== 1'b1 || resp_id !== 1'b0 || resp_c !== 32'd0 ||
             resp_flags !== 4'b1100) begin
            failures++;
            $display("FAIL bp_hold%0d: got v=%b id=%0d c=%h f=%b required 1/0/0/1100",
                     k, resp_valid, resp_id, resp_c, resp_flags);
         end
         if (req_ready !== 2'b00) begin
            failures++; $display("FAIL bp_ready%0d: got %b required 00", k, req_ready);
         end
         tick();
      end
      resp_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== 2'b10) begin
         failures++; $display("FAIL bp_regrant: got %b required 10", req_ready);
      end
      tick();
      req_valid[1] = 1'b0;
      drain();
   endtask

   task automatic test_masking();
      stale_en   = 1'b1;
      resp_ready = 1'b1;
      set_req(0, AluAnd, 32'hFFFF_0000, 32'h8000_FFFF);
      @(negedge clk);
      tick();
      req_valid[0] = 1'b0;
      @(negedge clk);
      tick();
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1 || resp_c !== 32'h8000_0000 || resp_flags !== 4'b0010) begin
         failures++;
         $display("FAIL mask_and: got v=%b c=%h f=%b required 1/80000000/0010",
                  resp_valid, resp_c, resp_flags);
      end
      tick();
      drain();
      stale_en = 1'b0;
   endtask

   task automatic test_none();
      resp_ready = 1'b1;
      set_req(1, AluNone, 32'h1234, 32'h5678);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (alu_control !== AluNone) begin
            failures++; $display("FAIL none_ctl%0d: got %0d required NONE", k, alu_control);
         end
         if (k == 0) begin
            checks++;
            if (req_ready !== 2'b10) begin
               failures++; $display("FAIL none_ready: got %b required 10", req_ready);
            end
         end
         if (k == 2) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_id !== 1'b1 || resp_c !== 32'd0 ||
                resp_flags !== 4'd0) begin
               failures++;
               $display("FAIL none_resp: got v=%b id=%0d c=%h f=%b required 1/1/0/0000",
                        resp_valid, resp_id, resp_c, resp_flags);
            end
         end
         tick();
         req_valid[1] = 1'b0;
      end
      drain();
   endtask

   task automatic test_reset_mid();
      bool_wait: begin end
      resp_ready = 1'b1;
      set_req(0, AluAdd, 32'd1, 32'd2);
      @(negedge clk);
      tick();
      req_valid[0] = 1'b0;
      rst_n        = 1'b0;
      @(negedge clk);
      tick();
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b0 || alu_control !== AluNone) begin
         failures++;
         $display("FAIL midrst: got v=%b ctl=%0d required 0/NONE", resp_valid, alu_control);
      end
      exp_q.delete();
      tick();
      rst_n = 1'b1;
      set_req(0, AluAdd, 32'd10, 32'd20);
      set_req(1, AluSub, 32'd9, 32'd4);
      @(negedge clk);
      checks++;
      if (req_ready !== 2'b01) begin
         failures++; $display("FAIL midrst_first: got %b required 01", req_ready);
      end
      tick();
      req_valid[0] = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (req_ready[1]) begin
            tick();
            req_valid[1] = 1'b0;
            break;
         end
         tick();
      end
      checks++;
      if (req_valid[1] !== 1'b0) begin
         failures++; $display("FAIL midrst_second: client 1 not granted, required grant");
         req_valid[1] = 1'b0;
      end
      drain();
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      stale_en    = 1'b0;
      rst_n       = 1'b0;
      req_valid   = '0;
      req_a       = '0;
      req_b       = '0;
      req_control = '0;
      resp_ready  = 1'b0;
      tick();
      test_reset();
      test_single_add();
      test_fairness();
      test_backpressure();
      test_masking();
      test_none();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
